md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//   Multi-cycle multiply/divide sequencer that owns the HI/LO registers of the 5-stage pipeline.
//   Sits in the E stage and consumes the decoder's 5-bit hiloCtrl code. Runs mult/div over a fixed busy window.
//   Commits HI/LO when the window ends and serves mfhi/mflo reads. Raises a stall request so D-stage HI/LO instructions wait.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk        in   1   clock, rising edge
//   reset_n    in   1   asynchronous, active-low reset
//   e_md_op    in   5   E-stage hiloCtrl: 0 none, 1 multu, 2 mult, 3 divu, 4 div, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//   e_flush    in   1   E-stage instruction cancelled this cycle (exception/eret); blocks start and writes
//   e_src_a    in   32  rs operand (forwarded)
//   e_src_b    in   32  rt operand (forwarded)
//   d_md_use   in   1   D-stage instruction has a non-zero hiloCtrl
//   start      out  1   combinational; E-stage op 1..4 accepted this cycle
//   busy       out  1   registered; operation in flight
//   stall_req  out  1   combinational; d_md_use & (start | busy)
//   rd_data    out  32  combinational; hi when e_md_op==5, lo when e_md_op==6, else 0
//   hi, lo     out  32  architectural HI/LO (debug/trace)
// BEHAVIOUR
//   - Reset (reset_n low, any time, async): state IDLE, count=0, busy=0, hi=lo=0, pending results=0. Any op in flight is dropped.
//   - FSM states: IDLE, RUN. start = (state==IDLE) & ~e_flush & e_md_op in {1,2,3,4}.
//   - IDLE -> RUN on start.
//     - At that edge latch the 64-bit result: multu = unsigned a*b; mult = signed a*b {hi,lo}.
//     - divu/div: hi=remainder, lo=quotient. Signed div truncates toward zero; remainder takes the sign of the dividend.
//     - Load count = MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
//   - RUN: busy=1; count decrements each edge. At the edge where count==1, commit hi/lo from the latch, count->0, go to IDLE.
//     - busy is high for exactly N cycles after the start cycle. New hi/lo are visible in the cycle after the last busy cycle.
//   - Divide by zero (b==0, ops 3/4): full busy window runs; hi/lo unchanged at commit.
//   - div 0x80000000 / -1: lo=0x80000000, hi=0.
//   - mthi/mtlo (7/8): write e_src_a to hi/lo at the edge when state==IDLE & ~e_flush. Ignored in RUN.
//   - mfhi/mflo in RUN: rd_data reads the old (committed) hi/lo. The hazard unit keeps such ops out of E via stall_req.
//   - e_md_op 1..4 while RUN or with e_flush: no start, no effect on the in-flight op.
//   - Once started, an operation is never cancelled by e_flush. Only reset aborts it.
//   - start and commit in the same cycle cannot occur (start requires IDLE).
//   - Codes 0 and 9..31: no action, rd_data=0.
// TESTING
//   - reset_n low mid-RUN (count=3) -> busy=0, hi=lo=0 immediately. After release, IDLE, no stale commit.
//   - mult a=0xFFFFFFFE b=3 -> start=1; busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   - multu a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//   - div a=-7 b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu a=7 b=0 -> hi/lo unchanged.
//   - d_md_use=1 during start cycle and every busy cycle -> stall_req=1. Drops to 0 on the first cycle with busy=0.
//   - div with e_flush=1 -> start=0, busy stays 0. mthi 0x1234 with e_flush=1 -> hi unchanged; without flush -> hi=0x1234; mfhi -> rd_data=0x1234.

Source files
------------

// File: rtl/md_sequencer_if.sv
// HI/LO sequencer bus: E-stage operation request, D-stage hazard input,
// and the sequencer's status, read-data and architectural HI/LO outputs.
interface md_sequencer_if;
    logic [4:0]  e_md_op;
    logic        e_flush;
    logic [31:0] e_src_a;
    logic [31:0] e_src_b;
    logic        d_md_use;
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output e_md_op, e_flush, e_src_a, e_src_b, d_md_use,
        input  start, busy, stall_req, rd_data, hi, lo
    );

    modport slave (
        input  e_md_op, e_flush, e_src_a, e_src_b, d_md_use,
        output start, busy, stall_req, rd_data, hi, lo
    );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// The 64-bit result is computed when the operation is accepted and held in a
// pending register; it is committed to HI/LO only when the busy window ends,
// so mfhi/mflo during the window still see the old architectural values.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    md_sequencer_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [4:0] OP_MULTU = 5'd1;
    localparam logic [4:0] OP_MULT  = 5'd2;
    localparam logic [4:0] OP_DIVU  = 5'd3;
    localparam logic [4:0] OP_DIV   = 5'd4;
    localparam logic [4:0] OP_MFHI  = 5'd5;
    localparam logic [4:0] OP_MFLO  = 5'd6;
    localparam logic [4:0] OP_MTHI  = 5'd7;
    localparam logic [4:0] OP_MTLO  = 5'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic               busy;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;
    logic               start;
    logic               commit;
    logic               is_md_op;
    logic               is_div;
    logic               div_by_zero;
    logic [63:0]        result;
    logic [CNT_W-1:0]   load_count;

    // Unsigned 32x32 -> 64 product.
    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Signed 32x32 -> 64 product (operands sign-extended to 64 bits first).
    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Unsigned divide, packed as {remainder, quotient}; caller guarantees b != 0.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of overflowing; quotient truncates toward zero and the
    // remainder follows the dividend's sign. Caller guarantees b != 0.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        mag_a = a[31] ? (~a + 32'd1) : a;
        mag_b = b[31] ? (~b + 32'd1) : b;
        q     = mag_a / mag_b;
        r     = mag_a % mag_b;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31])         r = ~r + 32'd1;
        return {r, q};
    endfunction

    assign is_md_op    = (bus.e_md_op >= OP_MULTU) && (bus.e_md_op <= OP_DIV);
    assign is_div      = (bus.e_md_op == OP_DIVU) || (bus.e_md_op == OP_DIV);
    assign div_by_zero = is_div && (bus.e_src_b == 32'd0);
    assign load_count  = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Operation result for the E-stage operands, latched only when accepted.
    always_comb begin
        result = 64'd0;
        case (bus.e_md_op)
            OP_MULTU: result = mul_unsigned(bus.e_src_a, bus.e_src_b);
            OP_MULT:  result = mul_signed(bus.e_src_a, bus.e_src_b);
            OP_DIVU:  if (!div_by_zero) result = div_unsigned(bus.e_src_a, bus.e_src_b);
            OP_DIV:   if (!div_by_zero) result = div_signed(bus.e_src_a, bus.e_src_b);
            default:  result = 64'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // FSM next state, start acceptance and end-of-window commit.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (is_md_op && !bus.e_flush) begin
                    start      = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (count == CNT_W'(1)) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Busy counter, pending result and architectural HI/LO updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else if (start) begin
            count   <= load_count;
            busy    <= 1'b1;
            pend_hi <= result[63:32];
            pend_lo <= result[31:0];
            pend_wr <= !div_by_zero;
        end else if (state == RUN) begin
            count <= count - CNT_W'(1);
            if (commit) begin
                busy <= 1'b0;
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end else if (!bus.e_flush) begin
            if (bus.e_md_op == OP_MTHI) hi <= bus.e_src_a;
            if (bus.e_md_op == OP_MTLO) lo <= bus.e_src_a;
        end
    end

    // Read port and hazard outputs.
    always_comb begin
        case (bus.e_md_op)
            OP_MFHI: bus.rd_data = hi;
            OP_MFLO: bus.rd_data = lo;
            default: bus.rd_data = 32'd0;
        endcase
    end

    assign bus.start     = start;
    assign bus.busy      = busy;
    assign bus.stall_req = bus.d_md_use & (start | busy);
    assign bus.hi        = hi;
    assign bus.lo        = lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: inputs driven on the falling edge,
// outputs sampled 1 ns later, expected values hand-computed.
module tb_md_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    md_sequencer_if bus ();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic flush, input logic duse);
        bus.e_md_op  = op;
        bus.e_src_a  = a;
        bus.e_src_b  = b;
        bus.e_flush  = flush;
        bus.d_md_use = duse;
    endtask

    // Start an op, hold iop (with optional flush) on E during the busy window,
    // then confirm commit timing and values.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic [4:0] iop, input logic run_flush);
        logic [31:0] exp_rd;
        exp_rd = (iop == 5'd5) ? old_hi : (iop == 5'd6) ? old_lo : 32'd0;
        @(negedge clk);
        drive(op, a, b, 1'b0, 1'b1);
        #1;
        check({name, "_start"}, bus.start, 1);
        check({name, "_stall_start"}, bus.stall_req, 1);
        check({name, "_busy_start"}, bus.busy, 0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            drive(iop, 32'hDEADBEEF, 32'h0000_0001, run_flush, 1'b1);
            #1;
            check($sformatf("%s_busy%0d", name, i), bus.busy, 1);
            check($sformatf("%s_nostart%0d", name, i), bus.start, 0);
            check($sformatf("%s_stall%0d", name, i), bus.stall_req, 1);
            check($sformatf("%s_oldhi%0d", name, i), bus.hi, old_hi);
            check($sformatf("%s_oldlo%0d", name, i), bus.lo, old_lo);
            check($sformatf("%s_rd%0d", name, i), bus.rd_data, exp_rd);
        end
        @(negedge clk);
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        #1;
        check({name, "_busy_end"}, bus.busy, 0);
        check({name, "_stall_end"}, bus.stall_req, 0);
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
        bus.d_md_use = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_stall", bus.stall_req, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("mult",  5'd2, 32'hFFFFFFFE, 32'd3, 5,
               32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5'd7, 1'b0);
        run_op("multu", 5'd1, 32'hFFFFFFFF, 32'd2, 5,
               32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFE, 5'd5, 1'b0);
        run_op("div",   5'd4, 32'hFFFFFFF9, 32'd2, 10,
               32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 5'd4, 1'b1);
        run_op("divu0", 5'd3, 32'd7, 32'd0, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 5'd6, 1'b0);
        run_op("divovf", 5'd4, 32'h80000000, 32'hFFFFFFFF, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000000, 32'h80000000, 5'd0, 1'b0);

        @(negedge clk);
        drive(5'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 check("mfhi_ovf", bus.rd_data, 32'h00000000);
        @(negedge clk);
        drive(5'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 check("mflo_ovf", bus.rd_data, 32'h80000000);

        // Asynchronous reset while count==3: everything clears, nothing commits later.
        @(negedge clk);
        drive(5'd4, 32'd100, 32'd7, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        end
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("postrst_busy", bus.busy, 0);
        check("postrst_hi", bus.hi, 0);
        check("postrst_lo", bus.lo, 0);

        // Flushed divide never starts.
        @(negedge clk);
        drive(5'd4, 32'd9, 32'd3, 1'b1, 1'b1);
        #1;
        check("flush_start", bus.start, 0);
        check("flush_stall", bus.stall_req, 0);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            #1 check($sformatf("flush_busy%0d", i), bus.busy, 0);
        end
        check("flush_lo", bus.lo, 0);

        // mthi / mtlo with and without flush, then reads.
        @(negedge clk);
        drive(5'd7, 32'h00001234, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 check("mthi_flush", bus.hi, 0);
        @(negedge clk);
        drive(5'd7, 32'h00001234, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(5'd8, 32'h00005678, 32'd0, 1'b0, 1'b0);
        #1 check("mthi_hi", bus.hi, 32'h00001234);
        @(negedge clk);
        drive(5'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 check("mfhi_rd", bus.rd_data, 32'h00001234);
        @(negedge clk);
        drive(5'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 check("mflo_rd", bus.rd_data, 32'h00005678);
        @(negedge clk);
        drive(5'd9, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
        #1 check("op9_rd", bus.rd_data, 32'h0);
        @(negedge clk);
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        check("op9_hi", bus.hi, 32'h00001234);
        check("op9_lo", bus.lo, 32'h00005678);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
